// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb
//
// Integer register file with a built-in busy-bit scoreboard. Decode reads
// operands through NUM_RD combinational read ports and claims destinations
// through the issue handshake; execute/memory writeback returns results on
// two write ports with fixed priority (port 0 over port 1).
//
// Each register carries a busy bit. Issuing to a register sets it and any
// writeback to that register clears it. Decode uses rbusy for RAW detection
// and iss_ready for WAW detection.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   : a read that matches a same-cycle write returns the write data
//               (port 0 preferred) and reports rbusy = 0.
//   undefined : reads return stored state only. rbusy stays high until the
//               edge that commits the write.
//
// Parameters
//   DATA_W  register width in bits
//   ADDR_W  register index width (2**ADDR_W registers)
//   NUM_RD  number of read ports (1..4)
//
// Ports
//   clk        single clock, rising-edge state updates
//   rst        synchronous active-high reset
//   we0/waddr0/wdata0   writeback port 0 (high priority)
//   we1/waddr1/wdata1   writeback port 1 (low priority)
//   re         per-port read enable, NUM_RD bits
//   raddr      packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rdata      packed read data, port i at [i*DATA_W +: DATA_W]
//   rbusy      per-port "read register has an unsatisfied pending write"
//   iss_valid  issue request claiming destination iss_rd
//   iss_rd     destination being claimed
//   iss_ready  claim accepted this cycle
// -----------------------------------------------------------------------------
module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we0,
    input  logic [ADDR_W-1:0]          waddr0,
    input  logic [DATA_W-1:0]          wdata0,
    input  logic                       we1,
    input  logic [ADDR_W-1:0]          waddr1,
    input  logic [DATA_W-1:0]          wdata1,
    input  logic [NUM_RD-1:0]          re,
    input  logic [NUM_RD*ADDR_W-1:0]   raddr,
    output logic [NUM_RD*DATA_W-1:0]   rdata,
    output logic [NUM_RD-1:0]          rbusy,
    input  logic                       iss_valid,
    input  logic [ADDR_W-1:0]          iss_rd,
    output logic                       iss_ready
);

    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   busy_nxt;

    // A write is only accepted when it targets a real register; r0 is
    // hard-wired to zero and never tracked.
    logic wr0_ok;
    logic wr1_ok;
    logic iss_fire;

    assign wr0_ok = we0 && (waddr0 != '0);
    assign wr1_ok = we1 && (waddr1 != '0);

    // ---------------------------------------------------------------------
    // Issue handshake. A busy destination may still be claimed when its
    // writeback lands this very cycle, since the old pending write retires
    // on the same edge the new claim is recorded.
    // ---------------------------------------------------------------------
    always_comb begin
        iss_ready = 1'b0;
        if (!rst) begin
            iss_ready = (iss_rd == '0)
                     || !busy[iss_rd]
                     || (wr0_ok && (waddr0 == iss_rd))
                     || (wr1_ok && (waddr1 == iss_rd));
        end
    end

    assign iss_fire = iss_valid && iss_ready;

    // ---------------------------------------------------------------------
    // Scoreboard next state. Writes clear first, then the issue sets, so a
    // same-cycle issue and write to the same register leaves it busy: the
    // new claim belongs to a younger instruction.
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // at the top; a path that skips an assignment would infer a latch.
        busy_nxt = busy;
        if (wr0_ok) busy_nxt[waddr0] = 1'b0;
        if (wr1_ok) busy_nxt[waddr1] = 1'b0;
        if (iss_fire && (iss_rd != '0)) busy_nxt[iss_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    // ---------------------------------------------------------------------
    // State registers.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            // NOTE: the register array is cleared on reset because software
            // observes registers as zero after reset; this costs a reset net
            // on every storage bit, so only do it where it is a contract.
            for (int k = 0; k < NREG; k++) begin
                regs[k] <= '0;
            end
            busy <= '0;
        end else begin
            // Port 1 is assigned first so that port 0, assigned last, wins
            // when both target the same register.
            if (wr1_ok) regs[waddr1] <= wdata1;
            if (wr0_ok) regs[waddr0] <= wdata0;
            busy <= busy_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // Read ports. Priority: reset, r0, disabled port, then data lookup.
    // ---------------------------------------------------------------------
    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd_val;
        logic              rb_val;

        assign ra = raddr[g*ADDR_W +: ADDR_W];

        always_comb begin
            rd_val = '0;
            rb_val = 1'b0;
            if (!rst && (ra != '0) && re[g]) begin
`ifdef REGFILE_BYPASS_EN
                // Forward in-flight writeback data; the value is available,
                // so the operand is no longer considered pending.
                if (wr0_ok && (waddr0 == ra)) begin
                    rd_val = wdata0;
                end else if (wr1_ok && (waddr1 == ra)) begin
                    rd_val = wdata1;
                end else begin
                    rd_val = regs[ra];
                    rb_val = busy[ra];
                end
`else
                rd_val = regs[ra];
                rb_val = busy[ra];
`endif
            end
        end

        assign rdata[g*DATA_W +: DATA_W] = rd_val;
        assign rbusy[g]                  = rb_val;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// -----------------------------------------------------------------------------
// tb_regfile_sb
//
// Self-checking bench for regfile_sb with four read ports. A table of
// per-cycle vectors drives inputs on the falling edge, checks combinational
// outputs shortly after, and lets the following rising edge commit state.
// Hand-written sequences cover reset at start-up and reset mid-operation.
// Expected values follow the REGFILE_BYPASS_EN setting of the build.
// -----------------------------------------------------------------------------
module tb_regfile_sb;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 4;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     we0;
    logic [ADDR_W-1:0]        waddr0;
    logic [DATA_W-1:0]        wdata0;
    logic                     we1;
    logic [ADDR_W-1:0]        waddr1;
    logic [DATA_W-1:0]        wdata1;
    logic [NUM_RD-1:0]        re;
    logic [NUM_RD*ADDR_W-1:0] raddr;
    logic [NUM_RD*DATA_W-1:0] rdata;
    logic [NUM_RD-1:0]        rbusy;
    logic                     iss_valid;
    logic [ADDR_W-1:0]        iss_rd;
    logic                     iss_ready;

    int errors = 0;
    int checks = 0;

    regfile_sb #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .we0       (we0),
        .waddr0    (waddr0),
        .wdata0    (wdata0),
        .we1       (we1),
        .waddr1    (waddr1),
        .wdata1    (wdata1),
        .re        (re),
        .raddr     (raddr),
        .rdata     (rdata),
        .rbusy     (rbusy),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_ready (iss_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         we0;
        logic [4:0]   wa0;
        logic [31:0]  wd0;
        logic         we1;
        logic [4:0]   wa1;
        logic [31:0]  wd1;
        logic         iv;
        logic [4:0]   ird;
        logic [3:0]   re;
        logic [19:0]  ra;
        logic [127:0] xrd;
        logic [3:0]   xrb;
        logic         xrdy;
    } vec_t;

    localparam int NVEC = 15;
    vec_t tbl [NVEC];

    function automatic logic [19:0] ra4(input logic [4:0] a3, input logic [4:0] a2,
                                        input logic [4:0] a1, input logic [4:0] a0);
        return {a3, a2, a1, a0};
    endfunction

    function automatic logic [127:0] rd4(input logic [31:0] d3, input logic [31:0] d2,
                                         input logic [31:0] d1, input logic [31:0] d0);
        return {d3, d2, d1, d0};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        we0 = 1'b0; waddr0 = '0; wdata0 = '0;
        we1 = 1'b0; waddr1 = '0; wdata1 = '0;
        iss_valid = 1'b0; iss_rd = '0;
        re = '0; raddr = '0;
    endtask

    task automatic check_outputs(input string tag, input logic [127:0] xrd,
                                 input logic [3:0] xrb, input logic xrdy);
        check({tag, " rdata"}, rdata, xrd);
        check({tag, " rbusy"}, {124'b0, rbusy}, {124'b0, xrb});
        check({tag, " iss_ready"}, {127'b0, iss_ready}, {127'b0, xrdy});
    endtask

    initial begin
        // ------------------------------------------------------------------
        // Vector table: one entry per cycle, expectations are the
        // combinational outputs seen before that cycle's rising edge.
        // ------------------------------------------------------------------
        // dual write to r7, port 0 data should win; read r7 same cycle
        tbl[0]  = '{1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22, 1'b0, 5'd0,
                    4'b0001, ra4(0, 0, 0, 7), rd4(0, 0, 0, BYP ? 32'h11 : 32'h0), 4'b0000, 1'b1};
        // r7 holds 0x11; write to r0 ignored and r0 reads 0
        tbl[1]  = '{1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
                    4'b0011, ra4(0, 0, 0, 7), rd4(0, 0, 0, 32'h11), 4'b0000, 1'b1};
        // r0 still 0; issue r5
        tbl[2]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5,
                    4'b0001, ra4(0, 0, 0, 0), rd4(0, 0, 0, 0), 4'b0000, 1'b1};
        // r5 busy; re-issue r5 stalls
        tbl[3]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5,
                    4'b0001, ra4(0, 0, 0, 5), rd4(0, 0, 0, 0), 4'b0001, 1'b0};
        // load writeback r5 = 0xAB; claim would be accepted
        tbl[4]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hAB, 1'b0, 5'd5,
                    4'b0001, ra4(0, 0, 0, 5), rd4(0, 0, 0, BYP ? 32'hAB : 32'h0),
                    BYP ? 4'b0000 : 4'b0001, 1'b1};
        // r5 settled; same-cycle issue and write r9
        tbl[5]  = '{1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9,
                    4'b0011, ra4(0, 0, 9, 5), rd4(0, 0, BYP ? 32'h99 : 32'h0, 32'hAB), 4'b0000, 1'b1};
        // r9 written and busy (issue wins); re-issue stalls
        tbl[6]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9,
                    4'b0010, ra4(0, 0, 9, 0), rd4(0, 0, 32'h99, 0), 4'b0010, 1'b0};
        // issue r4, preload r1/r2, no reads
        tbl[7]  = '{1'b1, 5'd1, 32'h10, 1'b1, 5'd2, 32'h20, 1'b1, 5'd4,
                    4'b0000, ra4(4, 3, 2, 1), rd4(0, 0, 0, 0), 4'b0000, 1'b1};
        // writeback r4 = 0x1234 and r3 = 0x30 while reading both
        tbl[8]  = '{1'b1, 5'd4, 32'h1234, 1'b1, 5'd3, 32'h30, 1'b0, 5'd0,
                    4'b0011, ra4(0, 0, 3, 4),
                    rd4(0, 0, BYP ? 32'h30 : 32'h0, BYP ? 32'h1234 : 32'h0),
                    BYP ? 4'b0000 : 4'b0001, 1'b1};
        // r4 now 0x1234, overwrite with 0x40
        tbl[9]  = '{1'b1, 5'd4, 32'h40, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
                    4'b0001, ra4(0, 0, 0, 4), rd4(0, 0, 0, BYP ? 32'h40 : 32'h1234), 4'b0000, 1'b1};
        // all four ports read r1..r4
        tbl[10] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
                    4'b1111, ra4(4, 3, 2, 1), rd4(32'h40, 32'h30, 32'h20, 32'h10), 4'b0000, 1'b1};
        // ports 1 and 3 disabled
        tbl[11] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
                    4'b0101, ra4(4, 3, 2, 1), rd4(0, 32'h30, 0, 32'h10), 4'b0000, 1'b1};
        // dual write r6 (bypass prefers port 0); r9 still busy
        tbl[12] = '{1'b1, 5'd6, 32'h66, 1'b1, 5'd6, 32'h77, 1'b0, 5'd0,
                    4'b1100, ra4(9, 6, 0, 0), rd4(32'h99, BYP ? 32'h66 : 32'h0, 0, 0), 4'b1000, 1'b1};
        // writeback r9 = 0x5A with a new claim on r9 in the same cycle
        tbl[13] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h5A, 1'b1, 5'd9,
                    4'b1100, ra4(9, 6, 0, 0), rd4(BYP ? 32'h5A : 32'h99, 32'h66, 0, 0),
                    BYP ? 4'b0000 : 4'b1000, 1'b1};
        // r9 holds 0x5A and stays busy for the new claim
        tbl[14] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
                    4'b1000, ra4(9, 0, 0, 0), rd4(32'h5A, 0, 0, 0), 4'b1000, 1'b1};

        // ------------------------------------------------------------------
        // Reset for two edges with a write and an issue presented.
        // ------------------------------------------------------------------
        idle_inputs();
        rst = 1'b1;
        we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'hDEAD;
        iss_valid = 1'b1; iss_rd = 5'd3;
        re = 4'b1111; raddr = ra4(3, 3, 3, 3);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            check_outputs($sformatf("reset%0d", c), '0, 4'b0000, 1'b0);
        end
        rst = 1'b0;
        idle_inputs();
        iss_rd = 5'd3;
        re = 4'b0001; raddr = ra4(0, 0, 0, 3);
        @(negedge clk);
        #1;
        check_outputs("post_reset r3", '0, 4'b0000, 1'b1);

        // ------------------------------------------------------------------
        // Table-driven cycles.
        // ------------------------------------------------------------------
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            we0 = tbl[i].we0; waddr0 = tbl[i].wa0; wdata0 = tbl[i].wd0;
            we1 = tbl[i].we1; waddr1 = tbl[i].wa1; wdata1 = tbl[i].wd1;
            iss_valid = tbl[i].iv; iss_rd = tbl[i].ird;
            re = tbl[i].re; raddr = tbl[i].ra;
            #1;
            check_outputs($sformatf("vec%0d", i), tbl[i].xrd, tbl[i].xrb, tbl[i].xrdy);
        end

        // ------------------------------------------------------------------
        // Reset mid-operation: r9 busy beforehand, everything cleared after.
        // ------------------------------------------------------------------
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        iss_valid = 1'b1; iss_rd = 5'd9;
        re = 4'b1001; raddr = ra4(9, 0, 0, 1);
        #1;
        check_outputs("mid_reset", '0, 4'b0000, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        iss_valid = 1'b0;
        #1;
        check_outputs("after_mid_reset", '0, 4'b0000, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
